// File: rtl/tug_pkg.sv
// Shared types and helpers for the tug-of-war match controller.
// Holds the controller state encoding, side constants and centre derivation.
package tug_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    ARMED     = 3'b001,
    LIVE      = 3'b010,
    WON       = 3'b011,
    MATCH_END = 3'b100
  } state_t;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  function automatic int tug_ctr(input int npos);
    return (npos - 1) / 2;
  endfunction

endpackage

// File: rtl/tug_match_ctrl_push_arb.sv
// Combinational push arbitration: turns the two player pushes plus the current
// phase into rope move strobes, applying the false-start penalty clamp.
module push_arb #(
  parameter int NPOS  = 9,
  parameter int POS_W = 4
) (
  input  logic             i_push_l,
  input  logic             i_push_r,
  input  logic             i_armed,
  input  logic             i_live,
  input  logic [POS_W-1:0] i_pos,
  output logic             o_move_dec,
  output logic             o_move_inc
);

  localparam logic [POS_W-1:0] P_LO = POS_W'(1);
  localparam logic [POS_W-1:0] P_HI = POS_W'(NPOS - 2);

  logic w_lone_l;
  logic w_lone_r;

  assign w_lone_l = i_push_l & ~i_push_r;
  assign w_lone_r = i_push_r & ~i_push_l;

  always_comb begin
    o_move_dec = 1'b0;
    o_move_inc = 1'b0;
    if (i_live) begin
      o_move_dec = w_lone_l;
      o_move_inc = w_lone_r;
    end else if (i_armed) begin
      // A false start pushes the rope away from the pusher's goal, never onto a goal.
      o_move_inc = w_lone_l && (i_pos < P_HI);
      o_move_dec = w_lone_r && (i_pos > P_LO);
    end
  end

endmodule

// File: rtl/tug_match_ctrl.sv
// Match-level tug-of-war controller: rope position, round wins, false-start
// penalties, per-player scores and best-of-N match termination.
module tug_match_ctrl
  import tug_pkg::*;
#(
  parameter int NPOS       = 9,
  parameter int POS_W      = 4,
  parameter int WIN_ROUNDS = 3,
  parameter int SCORE_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_l,
  input  logic               push_r,
  input  logic               clear,
  input  logic               live,
  output logic [POS_W-1:0]   pos,
  output logic               winrnd,
  output logic               round_winner,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               match_over,
  output logic               match_winner
);

  localparam logic [POS_W-1:0]   P_CTR  = POS_W'(tug_ctr(NPOS));
  localparam logic [POS_W-1:0]   P_ONE  = POS_W'(1);
  localparam logic [POS_W-1:0]   P_PRE  = POS_W'(NPOS - 2);
  localparam logic [SCORE_W-1:0] S_WIN  = SCORE_W'(WIN_ROUNDS);
  localparam logic [SCORE_W-1:0] S_ONE  = SCORE_W'(1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [POS_W-1:0]     r_pos;
  logic [POS_W-1:0]     w_pos_nxt;
  logic [POS_W-1:0]     w_pos_mv;
  logic                 r_winrnd;
  logic                 w_winrnd_nxt;
  logic                 r_round_winner;
  logic                 w_round_winner_nxt;
  logic [SCORE_W-1:0]   r_score_l;
  logic [SCORE_W-1:0]   r_score_r;
  logic [SCORE_W-1:0]   w_score_l_nxt;
  logic [SCORE_W-1:0]   w_score_r_nxt;
  logic                 r_match_over;
  logic                 w_match_over_nxt;
  logic                 r_match_winner;
  logic                 w_match_winner_nxt;
  logic                 w_move_dec;
  logic                 w_move_inc;
  logic                 w_win_l;
  logic                 w_win_r;
  logic                 w_win;
  logic [SCORE_W-1:0]   w_won_score;
  logic                 w_match_pt;

  push_arb #(
    .NPOS  (NPOS),
    .POS_W (POS_W)
  ) u_push_arb (
    .i_push_l   (push_l),
    .i_push_r   (push_r),
    .i_armed    (r_state == ARMED),
    .i_live     (r_state == LIVE),
    .i_pos      (r_pos),
    .o_move_dec (w_move_dec),
    .o_move_inc (w_move_inc)
  );

  always_comb begin
    w_pos_mv = r_pos;
    if (w_move_inc) begin
      w_pos_mv = r_pos + P_ONE;
    end else if (w_move_dec) begin
      w_pos_mv = r_pos - P_ONE;
    end
  end

  // Only a live push can land on a goal; the armed clamp keeps penalties off them.
  assign w_win_l     = (r_state == LIVE) && w_move_dec && (r_pos == P_ONE);
  assign w_win_r     = (r_state == LIVE) && w_move_inc && (r_pos == P_PRE);
  assign w_win       = w_win_l | w_win_r;
  assign w_won_score = (r_round_winner == RIGHT) ? r_score_r : r_score_l;
  assign w_match_pt  = (w_won_score == S_WIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (!clear) begin
          w_state_nxt = live ? LIVE : ARMED;
        end
      end
      ARMED: begin
        if (clear) begin
          w_state_nxt = IDLE;
        end else if (live) begin
          w_state_nxt = LIVE;
        end
      end
      LIVE: begin
        if (w_win) begin
          w_state_nxt = WON;
        end else if (clear) begin
          w_state_nxt = IDLE;
        end
      end
      WON: begin
        if (w_match_pt) begin
          w_state_nxt = MATCH_END;
        end else if (clear) begin
          w_state_nxt = IDLE;
        end
      end
      MATCH_END: w_state_nxt = MATCH_END;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_pos_nxt          = r_pos;
    w_winrnd_nxt       = 1'b0;
    w_round_winner_nxt = r_round_winner;
    w_score_l_nxt      = r_score_l;
    w_score_r_nxt      = r_score_r;
    w_match_over_nxt   = r_match_over;
    w_match_winner_nxt = r_match_winner;
    case (r_state)
      IDLE: w_pos_nxt = P_CTR;
      ARMED, LIVE: begin
        w_pos_nxt = (w_state_nxt == IDLE) ? P_CTR : w_pos_mv;
        if (w_win) begin
          w_winrnd_nxt       = 1'b1;
          w_round_winner_nxt = w_win_r ? RIGHT : LEFT;
          if (w_win_r) begin
            w_score_r_nxt = r_score_r + S_ONE;
          end else begin
            w_score_l_nxt = r_score_l + S_ONE;
          end
        end
      end
      WON: begin
        if (w_state_nxt == MATCH_END) begin
          w_match_over_nxt   = 1'b1;
          w_match_winner_nxt = r_round_winner;
        end else if (w_state_nxt == IDLE) begin
          w_pos_nxt = P_CTR;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos          <= P_CTR;
      r_winrnd       <= 1'b0;
      r_round_winner <= LEFT;
      r_score_l      <= '0;
      r_score_r      <= '0;
      r_match_over   <= 1'b0;
      r_match_winner <= LEFT;
    end else begin
      r_pos          <= w_pos_nxt;
      r_winrnd       <= w_winrnd_nxt;
      r_round_winner <= w_round_winner_nxt;
      r_score_l      <= w_score_l_nxt;
      r_score_r      <= w_score_r_nxt;
      r_match_over   <= w_match_over_nxt;
      r_match_winner <= w_match_winner_nxt;
    end
  end

  assign pos          = r_pos;
  assign winrnd       = r_winrnd;
  assign round_winner = r_round_winner;
  assign score_l      = r_score_l;
  assign score_r      = r_score_r;
  assign match_over   = r_match_over;
  assign match_winner = r_match_winner;

endmodule

// File: tb/tb_tug_match_ctrl.sv
// Self-checking bench for tug_match_ctrl: directed scenarios with literal
// expectations plus randomized play checked every cycle against a game model.
module tb_tug_match_ctrl;

  localparam int NPOS       = 9;
  localparam int POS_W      = 4;
  localparam int WIN_ROUNDS = 3;
  localparam int SCORE_W    = 2;
  localparam int CTR        = (NPOS - 1) / 2;

  localparam int M_IDLE  = 0;
  localparam int M_DARK  = 1;
  localparam int M_PLAY  = 2;
  localparam int M_GOAL  = 3;
  localparam int M_OVER  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic push_l = 1'b0;
  logic push_r = 1'b0;
  logic clear = 1'b1;
  logic live = 1'b0;
  logic [POS_W-1:0]   pos;
  logic               winrnd;
  logic               round_winner;
  logic [SCORE_W-1:0] score_l;
  logic [SCORE_W-1:0] score_r;
  logic               match_over;
  logic               match_winner;

  tug_match_ctrl #(
    .NPOS       (NPOS),
    .POS_W      (POS_W),
    .WIN_ROUNDS (WIN_ROUNDS),
    .SCORE_W    (SCORE_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_l       (push_l),
    .push_r       (push_r),
    .clear        (clear),
    .live         (live),
    .pos          (pos),
    .winrnd       (winrnd),
    .round_winner (round_winner),
    .score_l      (score_l),
    .score_r      (score_r),
    .match_over   (match_over),
    .match_winner (match_winner)
  );

  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;
  bit chk_en = 1'b0;

  // Game model: phase, rope position and scoreboard as plain integers.
  int m_mode, m_pos, m_sl, m_sr, m_rw, m_win, m_mo, m_mw;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mreset();
    m_mode = M_IDLE; m_pos = CTR; m_sl = 0; m_sr = 0;
    m_rw = 0; m_win = 0; m_mo = 0; m_mw = 0;
  endtask

  task automatic mstep(input bit pl, input bit pr, input bit c, input bit l);
    int step;
    int np;
    step = (pr && !pl) ? 1 : ((pl && !pr) ? -1 : 0);
    m_win = 0;
    case (m_mode)
      M_IDLE: begin
        m_pos = CTR;
        if (!c) m_mode = l ? M_PLAY : M_DARK;
      end
      M_DARK: begin
        np = m_pos - step;
        if (np < 1) np = 1;
        if (np > NPOS - 2) np = NPOS - 2;
        m_pos = np;
        if (c) begin m_mode = M_IDLE; m_pos = CTR; end
        else if (l) m_mode = M_PLAY;
      end
      M_PLAY: begin
        np = m_pos + step;
        if (np == 0 || np == NPOS - 1) begin
          m_pos = np; m_win = 1; m_rw = (np == 0) ? 0 : 1;
          if (m_rw == 1) m_sr++; else m_sl++;
          m_mode = M_GOAL;
        end else if (c) begin
          m_mode = M_IDLE; m_pos = CTR;
        end else begin
          m_pos = np;
        end
      end
      M_GOAL: begin
        if (((m_rw == 1) ? m_sr : m_sl) == WIN_ROUNDS) begin
          m_mode = M_OVER; m_mo = 1; m_mw = m_rw;
        end else if (c) begin
          m_mode = M_IDLE; m_pos = CTR;
        end
      end
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    if (!rst_n) mreset();
    else mstep(push_l, push_r, clear, live);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_pos", pos, m_pos);
      chk("m_winrnd", winrnd, m_win);
      chk("m_round_winner", round_winner, m_rw);
      chk("m_score_l", score_l, m_sl);
      chk("m_score_r", score_r, m_sr);
      chk("m_match_over", match_over, m_mo);
      if (m_mo != 0) chk("m_match_winner", match_winner, m_mw);
    end
  end

  task automatic drive(input bit pl, input bit pr, input bit c, input bit l);
    push_l = pl; push_r = pr; clear = c; live = l;
    @(posedge clk);
    #1;
    push_l = 1'b0; push_r = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    mreset();
    push_l = 1'b0; push_r = 1'b0; clear = 1'b1; live = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int over_cnt;
  int rate_l, rate_r;

  initial begin
    mreset();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pos", pos, 4);
    chk("rst_score_l", score_l, 0);
    chk("rst_score_r", score_r, 0);
    chk("rst_winrnd", winrnd, 0);
    chk("rst_match_over", match_over, 0);
    chk("rst_round_winner", round_winner, 0);
    chk("rst_match_winner", match_winner, 0);
    rst_n = 1'b1;
    drive(0, 0, 1, 0);

    // Left walks the rope home in four live pushes.
    drive(0, 0, 0, 1);
    repeat (3) drive(1, 0, 0, 1);
    chk("t1_pos1", pos, 1);
    drive(1, 0, 0, 1);
    chk("t1_pos0", pos, 0);
    chk("t1_winrnd", winrnd, 1);
    chk("t1_rw", round_winner, 0);
    chk("t1_score_l", score_l, 1);
    drive(0, 0, 0, 1);
    chk("t1_winrnd_off", winrnd, 0);
    chk("t1_pos_hold", pos, 0);
    drive(0, 0, 1, 0);
    chk("t1_pos_ctr", pos, 4);

    // Simultaneous pushes cancel.
    drive(0, 0, 0, 1);
    repeat (3) drive(1, 1, 0, 1);
    chk("t2_pos", pos, 4);
    chk("t2_winrnd", winrnd, 0);
    drive(0, 0, 1, 0);

    // False starts in the dark phase, with clamp at 1.
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    chk("t3_pos5", pos, 5);
    drive(0, 1, 0, 0);
    chk("t3_pos4", pos, 4);
    repeat (5) drive(0, 1, 0, 0);
    chk("t3_pos_sat", pos, 1);
    chk("t3_winrnd", winrnd, 0);

    // Abort at pos 2, then a win on the clear edge.
    drive(0, 0, 0, 1);
    drive(0, 1, 0, 1);
    chk("t4_pos2", pos, 2);
    drive(0, 0, 1, 1);
    chk("t4_abort_pos", pos, 4);
    chk("t4_abort_sl", score_l, 1);
    chk("t4_abort_sr", score_r, 0);
    drive(0, 0, 0, 1);
    repeat (3) drive(1, 0, 0, 1);
    drive(1, 0, 1, 1);
    chk("t4_win_pos", pos, 0);
    chk("t4_win_winrnd", winrnd, 1);
    chk("t4_win_sl", score_l, 2);
    drive(0, 0, 1, 0);

    // Right takes three rounds and the match.
    for (int r = 0; r < 3; r++) begin
      drive(0, 0, 0, 1);
      repeat (4) drive(0, 1, 0, 1);
      drive(0, 0, 1, 0);
    end
    chk("t5_match_over", match_over, 1);
    chk("t5_match_winner", match_winner, 1);
    chk("t5_score_r", score_r, 3);
    repeat (20) drive($urandom_range(0, 1), $urandom_range(0, 1),
                      $urandom_range(0, 1), $urandom_range(0, 1));
    chk("t5_pos_frozen", pos, 8);
    chk("t5_sl_frozen", score_l, 2);
    chk("t5_sr_frozen", score_r, 3);
    chk("t5_over_hold", match_over, 1);

    // Asynchronous reset in the middle of a live round.
    pulse_reset();
    for (int r = 0; r < 2; r++) begin
      drive(0, 0, 0, 1);
      repeat (4) drive(1, 0, 0, 1);
      drive(0, 0, 1, 0);
    end
    drive(0, 0, 0, 1);
    repeat (2) drive(0, 1, 0, 1);
    chk("t6_pos6", pos, 6);
    chk("t6_sl2", score_l, 2);
    #2;
    rst_n = 1'b0;
    mreset();
    clear = 1'b1; live = 1'b0;
    #1;
    chk("t6_rst_pos", pos, 4);
    chk("t6_rst_sl", score_l, 0);
    chk("t6_rst_sr", score_r, 0);
    chk("t6_rst_over", match_over, 0);
    chk("t6_rst_winrnd", winrnd, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized play with per-match push biases.
    over_cnt = 0;
    rate_l = $urandom_range(15, 50);
    rate_r = $urandom_range(15, 50);
    for (int i = 0; i < 2500; i++) begin
      if (m_mode == M_OVER) over_cnt++;
      if (over_cnt > 10) begin
        over_cnt = 0;
        rate_l = $urandom_range(15, 50);
        rate_r = $urandom_range(15, 50);
        pulse_reset();
      end
      if (clear) clear = ($urandom_range(0, 3) != 0);
      else clear = ($urandom_range(0, 39) == 0);
      if (live) live = ($urandom_range(0, 49) != 0);
      else live = ($urandom_range(0, 5) == 0);
      drive($urandom_range(0, 99) < rate_l, $urandom_range(0, 99) < rate_r, clear, live);
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/tug_match_ctrl.md
Name: tug_match_ctrl

Overview:
- Match-level controller for the tug-of-war datapath.
- Arbitrates the two players' push pulses into a single rope-position register and detects round wins; drives `winrnd` to the master game controller.
- Penalises false starts while the display is dark, keeps per-player scores, and ends the match at a best-of-N threshold.
- Sits between the debounced pushbutton inputs and the master controller / LED decoder.

Parameters:
- NPOS, 9: number of rope positions 0..NPOS-1. Centre CTR = (NPOS-1)/2. Must be odd and ≥ 5.
- POS_W, 4: width of `pos`. Must satisfy 2^POS_W ≥ NPOS.
- WIN_ROUNDS, 3: round wins needed to take the match.
- SCORE_W, 2: width of each score counter. Must satisfy 2^SCORE_W > WIN_ROUNDS.

Ports:
- clk, in, 1: system clock; all state updates on its rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- push_l, in, 1: left-player push, single-cycle pulse, already synchronised and debounced.
- push_r, in, 1: right-player push, same rules as `push_l`.
- clear, in, 1: from master controller; 1 = hold rope at centre / between rounds.
- live, in, 1: from master controller; 1 = play phase (LEDs lit, pushes count). Meaningful only when `clear` = 0.
- pos, out, POS_W: rope position; 0 = left goal, NPOS-1 = right goal.
- winrnd, out, 1: one-cycle pulse, round won.
- round_winner, out, 1: 0 = left, 1 = right. Valid from the `winrnd` cycle until the next `winrnd`.
- score_l, out, SCORE_W: left player's round wins.
- score_r, out, SCORE_W: right player's round wins.
- match_over, out, 1: high once a score reaches WIN_ROUNDS.
- match_winner, out, 1: 0 = left, 1 = right. Valid while `match_over` = 1.

Behaviour:
- Reset (`rst_n` low, asynchronous):
  - state = IDLE, `pos` = CTR.
  - `score_l` = `score_r` = 0.
  - `winrnd`, `round_winner`, `match_over`, `match_winner` all 0.
  - Reset mid-round or mid-match discards everything; no partial state survives.
- All outputs are registered.
- Push arbitration, evaluated per cycle:
  - `push_l` & `push_r` together: cancelled, no move, no penalty.
  - `push_l` alone: move = -1.
  - `push_r` alone: move = +1.
  - A move takes effect on the same edge that samples the push; `pos` shows the new value the following cycle.
- States:
  - IDLE:
    - `pos` forced to CTR.
    - Exit when `clear` = 0: to LIVE if `live` = 1, else to ARMED.
  - ARMED (dark; false-start window):
    - A lone push penalises the pusher by one step away from their own goal: `push_l` → `pos` + 1, `push_r` → `pos` - 1.
    - Penalty saturates at 1 and NPOS-2, so a penalty can never produce a win.
    - `live` = 1 → LIVE. `clear` = 1 → IDLE.
  - LIVE:
    - Lone push moves `pos` toward the pusher's goal.
    - If the new `pos` = 0: left wins. If it equals NPOS-1: right wins.
    - On a win: go to WON, assert `winrnd` for exactly one cycle (the cycle `pos` first shows the goal value), latch `round_winner`, and increment the winner's score.
    - `clear` = 1 with no win that edge → IDLE: round aborted, `pos` = CTR, no score change.
    - A winning push on the same edge that `clear` rises: the win takes precedence.
  - WON:
    - Pushes ignored; `pos` holds at the goal.
    - If the winner's score equals WIN_ROUNDS → MATCH_END.
    - Else wait for `clear` = 1, then → IDLE.
  - MATCH_END:
    - Terminal until reset.
    - `match_over` = 1; `match_winner` = `round_winner`.
    - Pushes, `clear` and `live` all ignored; `pos` holds; `winrnd` never re-asserts.
- Scores:
  - Increment only in LIVE → WON.
  - Never exceed WIN_ROUNDS.
  - The loser's score is unchanged.
- `live` = 1 with `clear` = 1: treated as `clear` (hold).

Decomposition:
- Shared package `tug_pkg`:
  - state enum {IDLE, ARMED, LIVE, WON, MATCH_END}, encoded 3'b000..3'b100.
  - side constants LEFT = 0, RIGHT = 1.
  - CTR derivation function.
- Sub-module `push_arb`: combinational arbitration of `push_l` / `push_r` plus phase (ARMED/LIVE) into move_dec / move_inc strobes, including the saturation rule.
- Score registers and the FSM stay in the top.

Test Plan:
- Reset then `clear` = 0, `live` = 1; four `push_l` pulses (NPOS = 9).
  - `pos` goes 4→3→2→1→0.
  - `winrnd` high for exactly 1 cycle with `pos` = 0; `round_winner` = 0; `score_l` = 1.
- LIVE at `pos` = 4; `push_l` and `push_r` in the same cycle, repeated 3 times → `pos` stays 4, no `winrnd`.
- ARMED at `pos` = 4: `push_l` → `pos` = 5; `push_r` → 4; five further `push_r` → `pos` saturates at 1, no `winrnd`.
- LIVE at `pos` = 2; raise `clear` with no push → next cycle state IDLE, `pos` = 4, scores unchanged.
  - Repeat with a winning push on the `clear` edge → win is scored.
- Right player wins 3 rounds (WIN_ROUNDS = 3).
  - `match_over` = 1, `match_winner` = 1, `score_r` = 3.
  - Further pushes and `clear` toggles leave `pos`/scores unchanged, with no `winrnd`.
- Assert `rst_n` low mid-LIVE at `pos` = 6 with `score_l` = 2 → immediately `pos` = 4, scores 0, `match_over` = 0, `winrnd` = 0.
